// File: rtl/mb_save_scheduler.sv
// Raster-order macroblock scheduler: requests each MB from the predictor, waits for its
// reconstruction (with timeout) and pulses the saver enable with the packed MB position.
module mb_save_scheduler #(
   parameter int WIDTH        = 720,
   parameter int LENGTH       = 1280,
   parameter int MB_SIZE_L    = 8,
   parameter int MB_SIZE_W    = 8,
   parameter int WAIT_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        pred_ready,
   input  logic        recon_valid,
   output logic        mb_req,
   output logic [31:0] mb_addr,
   output logic        save_en,
   output logic [31:0] mbnumber,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] mb_count,
   output logic        timeout_err
);

   localparam int TW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST_WAIT = TW'(WAIT_TIMEOUT - 1);
   localparam logic [15:0]   LAST_COL  = 16'(LENGTH - MB_SIZE_W);
   localparam logic [15:0]   LAST_ROW  = 16'(WIDTH - MB_SIZE_L);
   localparam logic [15:0]   COL_STEP  = 16'(MB_SIZE_W);
   localparam logic [15:0]   ROW_STEP  = 16'(MB_SIZE_L);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_SAVE, S_NEXT, S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [15:0]   row, col;
   logic [TW-1:0] wait_cnt;
   logic [31:0]   mbnumber_q;
   logic          timeout_hit;
   logic          accept_start;

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: if (pred_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            // a reconstruction arriving in the last timeout cycle still gets saved
            if (recon_valid) begin
               state_nxt = S_SAVE;
            end else if (wait_cnt == LAST_WAIT) begin
               state_nxt   = S_NEXT;
               timeout_hit = 1'b1;
            end
         end
         S_SAVE:  state_nxt = S_NEXT;
         S_NEXT:  state_nxt = (col == LAST_COL && row == LAST_ROW) ? S_DONE : S_ISSUE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   assign accept_start = (state == S_IDLE) && start && !abort;
   assign mb_addr      = {row, col};
   assign mb_req       = (state == S_ISSUE) && pred_ready;
   assign save_en      = (state == S_SAVE) && !abort;
   assign frame_done   = (state == S_DONE) && !abort;
   assign busy         = (state != S_IDLE);
   // mbnumber shows the live address during the save cycle and the latched one afterwards
   assign mbnumber     = save_en ? mb_addr : mbnumber_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         row         <= '0;
         col         <= '0;
         wait_cnt    <= '0;
         mbnumber_q  <= '0;
         mb_count    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == S_ISSUE)
            wait_cnt <= '0;
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 1'b1;

         if (save_en) begin
            mbnumber_q <= mb_addr;
            mb_count   <= mb_count + 16'd1;
         end

         if (timeout_hit && !abort)
            timeout_err <= 1'b1;

         if (state == S_NEXT && !abort) begin
            if (col == LAST_COL) begin
               col <= '0;
               if (row != LAST_ROW) row <= row + ROW_STEP;
            end else begin
               col <= col + COL_STEP;
            end
         end

         if (accept_start) begin
            row         <= '0;
            col         <= '0;
            mb_count    <= '0;
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mb_save_scheduler.sv
// Directed bench: dut_a scans a full default frame; dut_b (2x4 MBs, short timeout)
// covers timing, stalls, timeout, abort, reset and start/abort interplay.
module tb_mb_save_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic        a_reset, a_start, a_abort, a_pr, a_rv;
   logic        a_req, a_save, a_busy, a_fd, a_to;
   logic [31:0] a_addr, a_mbn;
   logic [15:0] a_cnt;

   logic        b_reset, b_start, b_abort, b_pr, b_rv;
   logic        b_req, b_save, b_busy, b_fd, b_to;
   logic [31:0] b_addr, b_mbn;
   logic [15:0] b_cnt;

   mb_save_scheduler dut_a (
      .clk(clk), .reset(a_reset), .start(a_start), .abort(a_abort),
      .pred_ready(a_pr), .recon_valid(a_rv), .mb_req(a_req), .mb_addr(a_addr),
      .save_en(a_save), .mbnumber(a_mbn), .busy(a_busy), .frame_done(a_fd),
      .mb_count(a_cnt), .timeout_err(a_to)
   );

   mb_save_scheduler #(.WIDTH(16), .LENGTH(32), .WAIT_TIMEOUT(16)) dut_b (
      .clk(clk), .reset(b_reset), .start(b_start), .abort(b_abort),
      .pred_ready(b_pr), .recon_valid(b_rv), .mb_req(b_req), .mb_addr(b_addr),
      .save_en(b_save), .mbnumber(b_mbn), .busy(b_busy), .frame_done(b_fd),
      .mb_count(b_cnt), .timeout_err(b_to)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // entered in ISSUE with pred_ready; returns at the cycle after NEXT
   task automatic do_mb(input logic [31:0] exp);
      b_pr = 1'b1;
      #1;
      chk("mb_req", 32'(b_req), 32'd1);
      chk("mb_addr", b_addr, exp);
      cyc();
      b_rv = 1'b1;
      #1;
      chk("wait_no_save", 32'(b_save), 32'd0);
      cyc();
      b_rv = 1'b0;
      #1;
      chk("save_en", 32'(b_save), 32'd1);
      chk("mbnumber", b_mbn, exp);
      cyc();
      #1;
      chk("save_once", 32'(b_save), 32'd0);
      cyc();
   endtask

   initial begin
      int er, ec, saves, fds;
      logic prev;

      a_reset = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_pr = 1'b1; a_rv = 1'b0;
      b_reset = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_pr = 1'b1; b_rv = 1'b0;
      cyc();
      cyc();
      a_reset = 1'b0;
      b_reset = 1'b0;
      #1;
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_addr", a_addr, 32'd0);
      chk("rst_mbnumber", a_mbn, 32'd0);
      chk("rst_count", 32'(a_cnt), 32'd0);
      chk("rst_to", 32'(a_to), 32'd0);
      chk("rst_save", 32'(a_save), 32'd0);
      chk("rst_fd", 32'(a_fd), 32'd0);
      chk("rst_req", 32'(a_req), 32'd0);
      cyc();

      // full default frame, recon_valid one cycle after each request
      a_start = 1'b1;
      cyc();
      a_start = 1'b0;
      prev = 1'b0; er = 0; ec = 0; saves = 0; fds = 0;
      for (int n = 0; n < 70000 && fds == 0; n++) begin
         a_rv = prev;
         #1;
         if (a_save) begin
            chk("t1_mbnumber", a_mbn, {er[15:0], ec[15:0]});
            saves++;
            ec += 8;
            if (ec == 1280) begin
               ec = 0;
               er += 8;
            end
         end
         if (a_fd) fds++;
         prev = a_req;
         cyc();
      end
      a_rv = 1'b0;
      chk("t1_frame_done", 32'(fds), 32'd1);
      chk("t1_saves", 32'(saves), 32'd14400);
      chk("t1_count", 32'(a_cnt), 32'd14400);
      chk("t1_idle", 32'(a_busy), 32'd0);
      chk("t1_fd_single", 32'(a_fd), 32'd0);

      // exact first-MB timing
      b_start = 1'b1;
      #1;
      chk("t2_busy0", 32'(b_busy), 32'd0);
      cyc();
      b_start = 1'b0;
      #1;
      chk("t2_req_c1", 32'(b_req), 32'd1);
      chk("t2_busy_c1", 32'(b_busy), 32'd1);
      chk("t2_addr_c1", b_addr, 32'd0);
      cyc();
      b_rv = 1'b1;
      #1;
      chk("t2_req_c2", 32'(b_req), 32'd0);
      chk("t2_save_c2", 32'(b_save), 32'd0);
      cyc();
      b_rv = 1'b0;
      #1;
      chk("t2_save_c3", 32'(b_save), 32'd1);
      chk("t2_mbn_c3", b_mbn, 32'd0);
      cyc();
      b_pr = 1'b0;
      #1;
      chk("t2_save_c4", 32'(b_save), 32'd0);
      chk("t2_count_c4", 32'(b_cnt), 32'd1);
      chk("t2_addr_c4", b_addr, 32'd0);
      cyc();
      #1;
      chk("t2_addr_c5", b_addr, 32'h0000_0008);
      chk("t3_req_stall", 32'(b_req), 32'd0);

      // predictor stalled for ten ISSUE cycles
      for (int i = 0; i < 9; i++) begin
         cyc();
         #1;
         chk("t3_req_stall", 32'(b_req), 32'd0);
         chk("t3_addr_stable", b_addr, 32'h0000_0008);
      end
      cyc();
      do_mb(32'h0000_0008);

      // MB (0,16) never reconstructed
      b_pr = 1'b1;
      #1;
      chk("t4_req", 32'(b_req), 32'd1);
      chk("t4_addr", b_addr, 32'h0000_0010);
      cyc();
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("t4_wait_save", 32'(b_save), 32'd0);
         chk("t4_wait_to", 32'(b_to), 32'd0);
         cyc();
      end
      #1;
      chk("t4_to_set", 32'(b_to), 32'd1);
      chk("t4_save", 32'(b_save), 32'd0);
      chk("t4_count", 32'(b_cnt), 32'd2);
      cyc();
      do_mb(32'h0000_0018);
      do_mb(32'h0008_0000);

      // abort while waiting on MB (8,8)
      b_pr = 1'b1;
      #1;
      chk("t5_req", 32'(b_req), 32'd1);
      chk("t5_addr", b_addr, 32'h0008_0008);
      cyc();
      b_abort = 1'b1;
      #1;
      chk("t5_busy_wait", 32'(b_busy), 32'd1);
      cyc();
      b_abort = 1'b0;
      #1;
      chk("t5_busy", 32'(b_busy), 32'd0);
      chk("t5_save", 32'(b_save), 32'd0);
      chk("t5_fd", 32'(b_fd), 32'd0);
      chk("t5_count_hold", 32'(b_cnt), 32'd4);
      chk("t5_to_hold", 32'(b_to), 32'd1);
      cyc();
      b_start = 1'b1;
      cyc();
      b_start = 1'b0;
      #1;
      chk("t5_restart_addr", b_addr, 32'd0);
      chk("t5_restart_count", 32'(b_cnt), 32'd0);
      chk("t5_restart_to", 32'(b_to), 32'd0);
      chk("t5_restart_req", 32'(b_req), 32'd1);
      cyc();

      // reset in WAIT with recon_valid high
      b_rv = 1'b1;
      b_reset = 1'b1;
      cyc();
      b_reset = 1'b0;
      #1;
      chk("t6_busy", 32'(b_busy), 32'd0);
      chk("t6_addr", b_addr, 32'd0);
      chk("t6_mbnumber", b_mbn, 32'd0);
      chk("t6_count", 32'(b_cnt), 32'd0);
      chk("t6_save", 32'(b_save), 32'd0);
      chk("t6_req", 32'(b_req), 32'd0);
      chk("t6_fd", 32'(b_fd), 32'd0);
      cyc();
      #1;
      chk("t6_rv_ignored", 32'(b_save), 32'd0);
      b_rv = 1'b0;
      b_start = 1'b1;
      cyc();
      b_pr = 1'b0;
      #1;
      chk("t6_busy_issue", 32'(b_busy), 32'd1);
      cyc();
      b_start = 1'b0;
      #1;
      chk("t6_start_ignored_addr", b_addr, 32'd0);
      chk("t6_start_ignored_req", 32'(b_req), 32'd0);

      // whole small frame, then DONE and abort-beats-start
      for (int r = 0; r < 16; r += 8)
         for (int c = 0; c < 32; c += 8)
            do_mb({r[15:0], c[15:0]});
      #1;
      chk("t7_frame_done", 32'(b_fd), 32'd1);
      chk("t7_busy_done", 32'(b_busy), 32'd1);
      chk("t7_count", 32'(b_cnt), 32'd8);
      chk("t7_mbn_hold", b_mbn, 32'h0008_0018);
      cyc();
      b_abort = 1'b1;
      b_start = 1'b1;
      #1;
      chk("t7_fd_pulse", 32'(b_fd), 32'd0);
      chk("t7_idle", 32'(b_busy), 32'd0);
      cyc();
      b_abort = 1'b0;
      b_start = 1'b0;
      #1;
      chk("t7_abort_wins", 32'(b_busy), 32'd0);
      chk("t7_count_hold", 32'(b_cnt), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
